note_staff_scheduler: RTL and testbench
=======================================

// Module: note_staff_scheduler
// PURPOSE
//   Schedules recognized notes onto the scrolling staff drawn by the note grid.
//   Buffers incoming note events in a small FIFO and places at most one note per staff column.
//   Advances the write column every SCROLL_FRAMES video frames.
//   The pixel renderer reads per-column contents through a registered read port.
// PARAMETERS
//   SLOTS          16  number of staff columns in the ring (power of 2)
//   FIFO_DEPTH     4   note input FIFO entries (power of 2)
//   SCROLL_FRAMES  30  frames per column advance (>=2)
//   is_simulation  0   1 = override SCROLL_FRAMES to 2 for fast benches
// PORTS
//   clk           in   1   pixel/system clock
//   reset_n       in   1   synchronous reset, active low
//   frame_start   in   1   1-cycle pulse, once per frame at vblank start
//   note_valid    in   1   note event valid
//   note_ready    out  1   FIFO can accept; transfer when valid&&ready
//   note_pitch    in   4   staff position 0..12 (0 = top line); 13..15 illegal
//   rd_slot       in   4   column index requested by renderer (log2 SLOTS bits)
//   rd_valid      out  1   column holds a note (registered, 1-cycle latency)
//   rd_pitch      out  4   pitch of that column (0 when rd_valid=0)
//   head_slot     out  4   column currently being written
//   fifo_level    out  3   entries in FIFO, 0..FIFO_DEPTH
//   drop_count    out  8   illegal pitches discarded, saturates at 255
// BEHAVIOUR
//   Reset (reset_n=0 at a clk edge): all slots invalid, head_slot=0, frame counter=0, FIFO empty.
//     rd_valid=0, rd_pitch=0, drop_count=0, fifo_level=0, note_ready=0, state=IDLE.
//     Reset asserted mid-operation aborts any state; no partial slot write.
//   note_ready = reset_n_q && (fifo_level < FIFO_DEPTH); registered level, no bypass.
//   Accepted pitch 13..15: handshake completes, not stored, drop_count+1 (saturating).
//   FSM: IDLE -> ADVANCE -> COMMIT -> IDLE.
//     IDLE: on frame_start, frame_cnt+1.
//       Leave for ADVANCE when frame_cnt==SCROLL_FRAMES-1; frame_cnt then returns to 0.
//     ADVANCE (1 cycle): head_slot = (head_slot+1) mod SLOTS (wraps SLOTS-1 -> 0).
//       The slot at the new head is cleared (valid=0).
//     COMMIT (1 cycle): if FIFO non-empty, pop one and write slot[head_slot]={1,pitch}.
//       If FIFO empty, the column stays blank.
//   frame_start during ADVANCE/COMMIT is ignored (not counted).
//   Push and pop in the same cycle: fifo_level unchanged.
//     Push is still gated by note_ready from the prior level.
//   FIFO full: note_ready=0; upstream holds note_valid/note_pitch stable; nothing is lost.
//   Read port: rd_valid/rd_pitch update 1 clk after rd_slot.
//     Read-before-write: a read of the slot being written in COMMIT returns the old contents.
//   Only one note per column: burst input backs up in FIFO and drains one per advance.
// TESTING
//   1 Reset with garbage inputs -> all rd_slot 0..15 give rd_valid=0; note_ready=1 one clk after release.
//   2 is_simulation=1, push pitch 5, 2 frame_starts -> head_slot=1; rd_slot=1 gives rd_valid=1, rd_pitch=5 after 1 clk.
//   3 Push 5 notes with no frame_start -> 4 accepted; 5th stalls with note_ready=0 until the first COMMIT, then accepted.
//   4 Push pitch 14 -> note_ready handshake completes, drop_count=1, fifo_level stays 0; 300 illegal -> drop_count=255.
//   5 Run 17 advances with one note each (pitch=n mod 13) -> head_slot wraps to 1; slot1 holds the newest note, the old one cleared.
//   6 reset_n low in the ADVANCE cycle -> head_slot=0, FIFO empty, no slot valid afterwards.

Source files
------------

// File: rtl/note_staff_scheduler.sv
// Scrolling-staff note scheduler: a small note FIFO feeds a ring of staff columns,
// one note per column, with the write head advancing every SCROLL_FRAMES frames.
module note_staff_scheduler #(
  parameter int SLOTS         = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int SCROLL_FRAMES = 30,
  parameter int is_simulation = 0,
  localparam int SW = $clog2(SLOTS),
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          frame_start,
  input  logic          note_valid,
  output logic          note_ready,
  input  logic [3:0]    note_pitch,
  input  logic [SW-1:0] rd_slot,
  output logic          rd_valid,
  output logic [3:0]    rd_pitch,
  output logic [SW-1:0] head_slot,
  output logic [LW-1:0] fifo_level,
  output logic [7:0]    drop_count
);

  localparam int SF_EFF = (is_simulation != 0) ? 2 : SCROLL_FRAMES;
  localparam int FW     = $clog2(SCROLL_FRAMES > 2 ? SCROLL_FRAMES : 2);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam logic [FW-1:0] LAST_FRAME = FW'(SF_EFF - 1);

  typedef enum logic [1:0] {IDLE, ADVANCE, COMMIT} state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] pitch;
  } slot_t;

  state_t                     state_q, state_d;
  logic [FW-1:0]              frame_cnt;
  slot_t [SLOTS-1:0]          slots;
  logic [FIFO_DEPTH-1:0][3:0] fifo_mem;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic                       reset_n_q;
  logic                       do_adv, do_commit;
  logic                       push, store, pop, legal;
  logic [SW-1:0]              head_nxt;

  // Ready comes from registered state only, so a pop never lets a push through the same cycle.
  assign note_ready = reset_n_q && (fifo_level < LW'(FIFO_DEPTH));
  assign legal      = (note_pitch <= 4'd12);
  assign push       = note_valid && note_ready;
  assign store      = push && legal;
  assign pop        = do_commit && (fifo_level != '0);
  assign head_nxt   = head_slot + 1'b1;

  always_comb begin
    state_d   = state_q;
    do_adv    = 1'b0;
    do_commit = 1'b0;
    case (state_q)
      IDLE:    if (frame_start && frame_cnt == LAST_FRAME) state_d = ADVANCE;
      ADVANCE: begin do_adv = 1'b1;    state_d = COMMIT; end
      COMMIT:  begin do_commit = 1'b1; state_d = IDLE;   end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) reset_n_q <= reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      frame_cnt  <= '0;
      slots      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
      head_slot  <= '0;
      rd_valid   <= 1'b0;
      rd_pitch   <= '0;
    end else begin
      state_q <= state_d;

      // Frames arriving while the head is moving are not counted.
      if (state_q == IDLE && frame_start)
        frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 1'b1;

      if (store) begin
        fifo_mem[wr_ptr] <= note_pitch;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({store, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      if (push && !legal && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;

      if (do_adv) begin
        head_slot             <= head_nxt;
        slots[head_nxt].valid <= 1'b0;
      end
      if (pop) slots[head_slot] <= '{valid: 1'b1, pitch: fifo_mem[rd_ptr]};

      // Sampled before this cycle's column write lands: read-before-write.
      rd_valid <= slots[rd_slot].valid;
      rd_pitch <= slots[rd_slot].valid ? slots[rd_slot].pitch : 4'd0;
    end
  end

endmodule

// File: tb/tb_note_staff_scheduler.sv
// Directed bench for note_staff_scheduler with the fast scroll rate (2 frames per column).
module tb_note_staff_scheduler;

  logic       clk = 1'b0;
  logic       reset_n, frame_start, note_valid, note_ready;
  logic [3:0] note_pitch, rd_slot, rd_pitch, head_slot;
  logic       rd_valid;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;

  int n_pass = 0;
  int n_tot  = 0;

  note_staff_scheduler #(.SLOTS(16), .FIFO_DEPTH(4), .SCROLL_FRAMES(30), .is_simulation(1)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .note_valid(note_valid), .note_ready(note_ready), .note_pitch(note_pitch),
    .rd_slot(rd_slot), .rd_valid(rd_valid), .rd_pitch(rd_pitch),
    .head_slot(head_slot), .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [3:0] p);
    int t = 0;
    note_valid = 1'b1; note_pitch = p;
    while (!note_ready && t < 50) begin tick(); t++; end
    if (t >= 50) chk("push_timeout", 0, 1);
    tick();
    note_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  // Two frames trigger ADVANCE, then ADVANCE and COMMIT each take one cycle.
  task automatic advance();
    frame(); frame(); tick(); tick();
  endtask

  task automatic rd(input logic [3:0] s, output logic v, output logic [3:0] p);
    rd_slot = s; tick(); v = rd_valid; p = rd_pitch;
  endtask

  logic       v;
  logic [3:0] p;
  int         nv;

  initial begin
    // 1: reset with garbage inputs
    reset_n = 1'b0; frame_start = 1'b1; note_valid = 1'b1; note_pitch = 4'd14; rd_slot = 4'd3;
    repeat (3) tick();
    chk("rst_ready", note_ready, 0);
    chk("rst_head", head_slot, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_rdv", rd_valid, 0);
    reset_n = 1'b1; frame_start = 1'b0; note_valid = 1'b0; note_pitch = 4'd0;
    chk("ready_before_clk", note_ready, 0);
    tick();
    chk("ready_after_clk", note_ready, 1);
    nv = 0;
    for (int s = 0; s < 16; s++) begin rd(s[3:0], v, p); nv += int'(v); end
    chk("rst_slots_valid", nv, 0);

    // 2: one note, one advance; read-before-write on the committing column
    push(4'd5);
    chk("t2_level", fifo_level, 1);
    frame(); frame();
    tick();
    chk("t2_head", head_slot, 1);
    rd_slot = 4'd1; tick();
    chk("t2_rbw_valid", rd_valid, 0);
    tick();
    chk("t2_rd_valid", rd_valid, 1);
    chk("t2_rd_pitch", rd_pitch, 5);
    chk("t2_level0", fifo_level, 0);
    rd(4'd0, v, p);
    chk("t2_slot0", v, 0);

    // 3: five pushes without frames; fifth stalls until the first COMMIT
    for (int i = 1; i <= 4; i++) push(i[3:0]);
    chk("t3_full_level", fifo_level, 4);
    chk("t3_full_ready", note_ready, 0);
    note_valid = 1'b1; note_pitch = 4'd6;
    tick(); tick();
    chk("t3_stall_level", fifo_level, 4);
    frame(); frame(); tick();
    chk("t3_adv_ready", note_ready, 0);
    tick();
    chk("t3_commit_ready", note_ready, 1);
    chk("t3_commit_level", fifo_level, 3);
    tick(); note_valid = 1'b0;
    chk("t3_accept_level", fifo_level, 4);
    rd(4'd2, v, p);
    chk("t3_slot2", {v, p}, {1'b1, 4'd1});
    repeat (4) advance();
    chk("t3_head", head_slot, 6);
    chk("t3_drained", fifo_level, 0);
    rd(4'd3, v, p);
    chk("t3_slot3", {v, p}, {1'b1, 4'd2});
    rd(4'd6, v, p);
    chk("t3_slot6", {v, p}, {1'b1, 4'd6});

    // 4: illegal pitches are dropped and counted, saturating
    push(4'd14);
    chk("t4_drop1", drop_count, 1);
    chk("t4_level", fifo_level, 0);
    note_valid = 1'b1; note_pitch = 4'd15;
    repeat (300) tick();
    note_valid = 1'b0;
    chk("t4_drop_sat", drop_count, 255);
    chk("t4_level_sat", fifo_level, 0);

    // 5: 17 advances from reset wrap the head; an empty advance clears the column
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    for (int n = 0; n < 17; n++) begin push(4'(n % 13)); advance(); end
    chk("t5_head", head_slot, 1);
    rd(4'd1, v, p);
    chk("t5_slot1", {v, p}, {1'b1, 4'd3});
    rd(4'd0, v, p);
    chk("t5_slot0", {v, p}, {1'b1, 4'd2});
    rd(4'd2, v, p);
    chk("t5_slot2_old", {v, p}, {1'b1, 4'd1});
    advance();
    chk("t5_head2", head_slot, 2);
    rd(4'd2, v, p);
    chk("t5_slot2_cleared", {v, p}, {1'b0, 4'd0});

    // 6: reset in the ADVANCE cycle
    push(4'd7);
    frame(); frame();
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    chk("t6_head", head_slot, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_drop", drop_count, 0);
    nv = 0;
    for (int s = 0; s < 16; s++) begin rd(s[3:0], v, p); nv += int'(v); end
    chk("t6_slots_valid", nv, 0);
    repeat (4) tick();
    chk("t6_head_stays", head_slot, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
